// File: rtl/xadc_temp_bcd_pkg.sv
// Shared constants and helpers for the XADC die-temperature readout.
//   SCALE/SHIFT/OFFSET : tenths_c = ((code * SCALE) >> SHIFT) - OFFSET
//   DRP_ADDR_TEMP      : XADC temperature status register
//   state_t            : sequencing FSM encoding
//   bcd_adjust()       : double-dabble add-3 step over four BCD nibbles
package xadc_temp_bcd_pkg;

  localparam int unsigned SCALE         = 20159;
  localparam int unsigned SHIFT         = 14;
  localparam int unsigned OFFSET        = 2732;
  localparam int unsigned BCD_ITER      = 12;
  localparam logic [6:0]  DRP_ADDR_TEMP = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_MUL,
    ST_BCD,
    ST_COMMIT
  } state_t;

  // Any nibble >= 5 gets +3 so that the following left shift carries
  // correctly into the next decimal digit.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/xadc_temp_bcd_bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter (double-dabble),
// one bit per clock, 12 clocks per conversion.
//   clk, rst : clock, async active-high reset
//   start    : load bin and begin a conversion (restarts one in flight)
//   bin      : 12-bit binary value, sampled on start
//   bcd      : BCD result register; final once the done cycle has passed
//   done     : high during the last iteration; bcd is valid the next cycle
module bin2bcd_seq
  import xadc_temp_bcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [11:0] sh_bin;
  logic [15:0] adj;
  logic [3:0]  iter_cnt;

  assign adj  = bcd_adjust(bcd);
  // Combinational done lets the caller leave its wait state on the same
  // edge that performs the final shift, so no extra idle cycle is spent.
  assign done = (iter_cnt == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_bin   <= '0;
      bcd      <= '0;
      iter_cnt <= '0;
    end else if (start) begin
      sh_bin   <= bin;
      bcd      <= '0;
      iter_cnt <= 4'(BCD_ITER);
    end else if (iter_cnt != 4'd0) begin
      bcd      <= {adj[14:0], sh_bin[11]};
      sh_bin   <= {sh_bin[10:0], 1'b0};
      iter_cnt <= iter_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/xadc_temp_bcd.sv
// XADC die temperature reader: on a trigger rising edge, reads the
// temperature code over DRP, scales it to tenths of a degree C, converts
// to BCD and holds the digits for the debug overlay.
//   clk, rst              : clock, async active-high reset
//   trigger               : level request, rising edge starts a read
//   drp_den/dwe/daddr     : DRP request (read-only, fixed address)
//   drp_drdy, drp_do      : DRP response, code in drp_do[15:4]
//   temp_ent_bcd          : integer degrees, 3 BCD digits
//   temp_dec_bcd          : tenths digit
//   busy                  : read in progress
//   timeout_err           : sticky DRP timeout flag, cleared on commit
//   testigo               : toggles on each successful commit
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for a trigger rising edge
// ST_REQ    | one-cycle DRP read strobe, arm timeout counter
// ST_WAIT   | wait for drdy or timeout
// ST_MUL    | scale/offset/clamp code, launch BCD conversion
// ST_BCD    | double-dabble running
// ST_COMMIT | publish digits, clear error, toggle testigo
module xadc_temp_bcd
  import xadc_temp_bcd_pkg::*;
#(
  parameter int         TIMEOUT  = 1023,
  parameter logic [6:0] DRP_ADDR = DRP_ADDR_TEMP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [6:0]  drp_daddr,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic [11:0] temp_ent_bcd,
  output logic [3:0]  temp_dec_bcd,
  output logic        busy,
  output logic        timeout_err,
  output logic        testigo
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state, state_nxt;
  logic          trig_q;
  logic          start;
  logic [11:0]   code;
  logic [CW-1:0] wait_cnt;
  logic          bcd_start, bcd_done;
  logic          do_commit, do_timeout;
  logic [15:0]   bcd;
  logic [26:0]   prod;
  logic [15:0]   scaled;
  logic [15:0]   t_raw;
  logic [11:0]   t_clamp;
  logic          unused_do_lsbs;

  assign unused_do_lsbs = ^drp_do[3:0];

  assign drp_dwe   = 1'b0;
  assign drp_daddr = DRP_ADDR;
  assign busy      = (state != ST_IDLE);
  assign start     = trigger & ~trig_q & (state == ST_IDLE);

  // Product peaks near 82.5M (code 0xFFF), so 27 bits never overflow;
  // after the shift the value fits comfortably in 16 bits.
  assign prod    = 27'(code) * 27'(SCALE);
  assign scaled  = 16'(prod >> SHIFT);
  assign t_raw   = scaled - 16'(OFFSET);
  assign t_clamp = t_raw[15] ? 12'd0 : 12'(t_raw);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    drp_den    = 1'b0;
    bcd_start  = 1'b0;
    do_commit  = 1'b0;
    do_timeout = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        drp_den   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (drp_drdy) begin
          state_nxt = ST_MUL;
        end else if (wait_cnt == '0) begin
          do_timeout = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      ST_MUL: begin
        bcd_start = 1'b1;
        state_nxt = ST_BCD;
      end
      ST_BCD:    if (bcd_done) state_nxt = ST_COMMIT;
      ST_COMMIT: begin
        do_commit = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q       <= 1'b0;
      code         <= '0;
      wait_cnt     <= '0;
      temp_ent_bcd <= 12'h000;
      temp_dec_bcd <= 4'h0;
      timeout_err  <= 1'b0;
      testigo      <= 1'b0;
    end else begin
      trig_q <= trigger;
      // Down-counter: loaded in REQ, terminal count 0 in WAIT gives
      // TIMEOUT+1 WAIT cycles before abandoning the read.
      if (state == ST_REQ)
        wait_cnt <= CW'(TIMEOUT);
      else if (state == ST_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (state == ST_WAIT && drp_drdy)
        code <= drp_do[15:4];
      if (do_timeout)
        timeout_err <= 1'b1;
      if (do_commit) begin
        temp_ent_bcd <= bcd[15:4];
        temp_dec_bcd <= bcd[3:0];
        timeout_err  <= 1'b0;
        testigo      <= ~testigo;
      end
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (t_clamp),
    .bcd   (bcd),
    .done  (bcd_done)
  );

endmodule

// File: doc/xadc_temp_bcd.md
# xadc_temp_bcd

Upstream measurement stage for the on-screen debug overlay. On each rising edge of a measurement trigger it reads the FPGA die temperature from the XADC through its DRP port. It converts the 12-bit code to tenths of a degree Celsius in fixed point, then converts that value to BCD with a sequential double-dabble. The overlay renders the held integer and decimal BCD digits directly in its temperature field.

## Interface
Parameters:
- TIMEOUT, 1023: DRP wait limit in clk cycles before abandoning a read.
- DRP_ADDR, 7'h00: XADC temperature status register address.

Ports:
- clk  in  1  system clock; every register is on its rising edge.
- rst  in  1  reset; **asynchronous, active-high** (already decided). While high, every register holds its reset value.
- trigger  in  1  measurement request. Level input, may stay high for many cycles; only its rising edge starts a read.
- drp_den  out  1  DRP enable, one-cycle pulse.
- drp_dwe  out  1  DRP write enable, constant 0.
- drp_daddr  out  7  DRP address, constant DRP_ADDR.
- drp_drdy  in  1  DRP read-data valid.
- drp_do  in  16  DRP read data; ADC code is bits [15:4].
- temp_ent_bcd  out  12  integer degrees as 3 BCD digits (hundreds, tens, units).
- temp_dec_bcd  out  4  tenths digit, BCD.
- busy  out  1  high from trigger acceptance until results commit or timeout.
- timeout_err  out  1  sticky; set on DRP timeout, cleared by the next successful commit.
- testigo  out  1  toggles on each successful commit (activity LED).

## Operation
- Trigger edge detect: trig_q registers trigger; start = trigger & ~trig_q & (state==IDLE).
  - A rising edge while not IDLE is ignored, not queued.
- FSM states: IDLE, REQ, WAIT, MUL, BCD, COMMIT.
  - IDLE -> REQ on start.
  - REQ: drp_den=1 for exactly one cycle; clear wait counter; -> WAIT.
  - WAIT: on drp_drdy, capture code=drp_do[15:4] -> MUL. If the counter reaches TIMEOUT without drdy, set timeout_err -> IDLE; outputs keep their old values.
  - MUL: t = ((code × 20159) >> 14) − 2732, signed 16-bit. The product is 27-bit unsigned. If t < 0, t = 0. Max t = 2306 (code 0xFFF).
  - BCD: shift-add-3 double-dabble over 12 bits of t into a 16-bit BCD register, 12 cycles. Before each shift, any nibble ≥5 gets +3.
  - COMMIT: temp_ent_bcd = bcd[15:4], temp_dec_bcd = bcd[3:0]; clear timeout_err; toggle testigo -> IDLE.
- drp_drdy outside WAIT is ignored.
- busy = (state != IDLE).

## Timing
- Reset values: drp_den 0, drp_dwe 0, drp_daddr DRP_ADDR, temp_ent_bcd 12'h000, temp_dec_bcd 4'h0, busy 0, timeout_err 0, testigo 0; FSM IDLE; trig_q 0.
- Edge of trigger seen in cycle N; start is combinational in that cycle; REQ in N+1 (drp_den high); WAIT from N+2.
- drdy in cycle M leads to MUL at M+1, BCD at M+2..M+13, COMMIT at M+14. Outputs are visible from M+15.
- Fixed latency from drdy to new outputs is 15 cycles.
- Timeout: timeout_err rises TIMEOUT+1 cycles after entering WAIT.
- Outputs change only in COMMIT, so they are stable for the overlay's full scan line.
- Reset asserted mid-read: FSM returns to IDLE at once and outputs return to reset values. A drdy arriving after reset release is ignored.

## Structure
- Shared package constants: the scale factor 20159, shift 14, offset 2732, DRP_ADDR default, and the FSM state encoding.
- One natural sub-module: bin2bcd_seq (12-bit in, 16-bit BCD out, start/done handshake, 12-cycle iteration). It is reusable for other overlay readouts.

## Test plan
- Reset, then trigger edge with drp_do=16'h9D80 after 5 cycles -> temp_ent_bcd=12'h036, temp_dec_bcd=4'h8, testigo 0->1, busy low 15 cycles after drdy.
- drp_do=16'hFFF0 -> 12'h230 / 4'h6; drp_do=16'h8FC0 (code 2300) -> 12'h009 / 4'h7.
- Code 2220 (drp_do=16'h8AC0) -> clamp gives 12'h000 / 4'h0; outputs update, testigo toggles.
- Hold trigger high 500 cycles -> exactly one drp_den pulse. Second rising edge while busy -> no extra drp_den.
- No drdy -> timeout_err=1 after TIMEOUT+1 cycles in WAIT, previous values held. Next good read clears timeout_err.
- Assert rst during BCD -> all outputs return to reset values immediately. A late drdy causes no update.
